multdiv_ctrl: RTL

//  Execute-stage sequencer for the multi-cycle multiplier/divider. Detects mul/div in the DX latch,

---
 rtl/multdiv_ctrl_pkg.sv | 30 +++
 rtl/multdiv_ctrl_if.sv | 40 ++++
 rtl/multdiv_ctrl_md_cycle_counter.sv | 29 ++
 rtl/multdiv_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/multdiv_ctrl_pkg.sv
// multdiv_ctrl_pkg: shared definitions for the execute-stage multiply/divide sequencer.
//   Widths, instruction field codes, exception codes, FSM state encodings and the
//   mul/div instruction decode helper.
//   Optional feature macro used by the consumers: MULTDIV_TIMEOUT_EN.
package multdiv_ctrl_pkg;

  localparam int DATA_W         = 32;
  localparam int CNT_W          = 6;
  localparam int TIMEOUT_CYCLES = 40;
  localparam int RSTATUS_REG    = 30;
  localparam int MUL_EXC_CODE   = 4;
  localparam int DIV_EXC_CODE   = 5;

  localparam logic [4:0] OPC_RTYPE = 5'b00000;
  localparam logic [4:0] ALUOP_ADD = 5'b00000;
  localparam logic [4:0] ALUOP_MUL = 5'b00110;
  localparam logic [4:0] ALUOP_DIV = 5'b00111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  // True for R-type mul or div; fields passed separately so no unused insn bits leak in.
  function automatic logic is_md_op(input logic [4:0] opcode, input logic [4:0] aluop);
    return (opcode == OPC_RTYPE) && ((aluop == ALUOP_MUL) || (aluop == ALUOP_DIV));
  endfunction

endpackage

// File: rtl/multdiv_ctrl_if.sv
// multdiv_ctrl_if: bundle between the X-stage sequencer, the DX/XM latches and the
//   multi-cycle multdiv unit.
//   slave  : sequencer side (takes DX insn/operands and multdiv status, drives the rest)
//   master : pipeline/multdiv side (the mirror image)
//   Signals: dx_insn, dx_a, dx_b, md_result, md_ready, md_exception (to sequencer);
//            md_op_a, md_op_b, md_start_mult, md_start_div, stall, xm_bubble,
//            res_valid, res_data, res_rd, md_timeout (from sequencer).
interface multdiv_ctrl_if import multdiv_ctrl_pkg::*; ();

  logic [31:0]       dx_insn;
  logic [DATA_W-1:0] dx_a;
  logic [DATA_W-1:0] dx_b;
  logic [DATA_W-1:0] md_result;
  logic              md_ready;
  logic              md_exception;

  logic [DATA_W-1:0] md_op_a;
  logic [DATA_W-1:0] md_op_b;
  logic              md_start_mult;
  logic              md_start_div;
  logic              stall;
  logic              xm_bubble;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic [4:0]        res_rd;
  logic              md_timeout;

  modport slave (
    input  dx_insn, dx_a, dx_b, md_result, md_ready, md_exception,
    output md_op_a, md_op_b, md_start_mult, md_start_div, stall, xm_bubble,
           res_valid, res_data, res_rd, md_timeout
  );

  modport master (
    output dx_insn, dx_a, dx_b, md_result, md_ready, md_exception,
    input  md_op_a, md_op_b, md_start_mult, md_start_div, stall, xm_bubble,
           res_valid, res_data, res_rd, md_timeout
  );

endinterface

// File: rtl/multdiv_ctrl_md_cycle_counter.sv
// multdiv_ctrl_md_cycle_counter: busy-cycle up-counter for the multdiv sequencer.
//   i_clock : rising-edge clock
//   i_clear : synchronous clear (dominates enable)
//   i_en    : count enable
//   o_tc    : terminal flag, high while the count equals TC_VAL; the count
//             stops at TC_VAL so the flag stays up until cleared.
module multdiv_ctrl_md_cycle_counter #(
  parameter int CNT_W  = 6,
  parameter int TC_VAL = 39
) (
  input  logic i_clock,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tc = (r_cnt == CNT_W'(TC_VAL));

endmodule

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: execute-stage sequencer for the multi-cycle multiplier/divider.
//   Detects mul/div in DX, freezes PC/FD/DX and bubbles XM while the unit runs,
//   then presents the result (or an rstatus exception write) for one cycle.
//   i_clock : rising-edge clock
//   i_reset : synchronous, active-high
//   io_md   : multdiv_ctrl_if.slave bundle (DX inputs, multdiv handshake, XM result)
//   Macro MULTDIV_TIMEOUT_EN: enables the busy watchdog and the sticky md_timeout flag.
//
//   state | meaning
//   IDLE  | no op in flight; stalls combinationally the cycle a mul/div shows up in DX
//   BUSY  | unit running; start pulse in the first cycle, waiting for md_ready
//   DONE  | one-cycle result handoff to XM; DX still holds the finished insn
module multdiv_ctrl import multdiv_ctrl_pkg::*; (
  input  logic           i_clock,
  input  logic           i_reset,
  multdiv_ctrl_if.slave  io_md
);

  localparam logic [DATA_W-1:0] MUL_EXC_WORD = DATA_W'(MUL_EXC_CODE);
  localparam logic [DATA_W-1:0] DIV_EXC_WORD = DATA_W'(DIV_EXC_CODE);
  localparam logic [4:0]        RSTATUS_IDX  = 5'(RSTATUS_REG);

  md_state_e         r_state;
  md_state_e         w_state_nxt;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic [DATA_W-1:0] r_result;
  logic [4:0]        r_rd;
  logic              r_is_div;
  logic              r_exc;
  logic              r_start_mult;
  logic              r_start_div;
  logic              w_is_md;
  logic              w_is_div_insn;
  logic              w_tc;
  logic              w_timeout_hit;
  logic              w_unused_insn;

  assign w_is_md       = is_md_op(io_md.dx_insn[31:27], io_md.dx_insn[6:2]);
  assign w_is_div_insn = (io_md.dx_insn[6:2] == ALUOP_DIV);
  assign w_unused_insn = ^{io_md.dx_insn[21:7], io_md.dx_insn[1:0]};

  // Held clear outside BUSY, so BUSY cycle k sees count k-1.
  multdiv_ctrl_md_cycle_counter #(
    .CNT_W  (CNT_W),
    .TC_VAL (TIMEOUT_CYCLES - 1)
  ) u_cnt (
    .i_clock (i_clock),
    .i_clear (i_reset || (r_state != ST_BUSY)),
    .i_en    (r_state == ST_BUSY),
    .o_tc    (w_tc)
  );

`ifdef MULTDIV_TIMEOUT_EN
  logic r_timeout;

  assign w_timeout_hit = w_tc && !io_md.md_ready;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_timeout <= 1'b0;
    end else if ((r_state == ST_BUSY) && w_timeout_hit) begin
      r_timeout <= 1'b1;
    end
  end

  assign io_md.md_timeout = r_timeout;
`else
  logic w_unused_tc;

  assign w_unused_tc      = w_tc;
  assign w_timeout_hit    = 1'b0;
  assign io_md.md_timeout = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // DONE never looks at DX: the finished insn is still there and must not restart.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_is_md) w_state_nxt = ST_BUSY;
      ST_BUSY: if (io_md.md_ready || w_timeout_hit) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    io_md.stall     = ((r_state == ST_IDLE) && w_is_md) || (r_state == ST_BUSY);
    io_md.xm_bubble = io_md.stall;
    io_md.res_valid = 1'b0;
    io_md.res_data  = '0;
    io_md.res_rd    = '0;
    if (r_state == ST_DONE) begin
      io_md.res_valid = 1'b1;
      if (r_exc) begin
        io_md.res_data = r_is_div ? DIV_EXC_WORD : MUL_EXC_WORD;
        io_md.res_rd   = RSTATUS_IDX;
      end else begin
        io_md.res_data = r_result;
        io_md.res_rd   = r_rd;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_result     <= '0;
      r_rd         <= '0;
      r_is_div     <= 1'b0;
      r_exc        <= 1'b0;
      r_start_mult <= 1'b0;
      r_start_div  <= 1'b0;
    end else begin
      r_start_mult <= 1'b0;
      r_start_div  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_is_md) begin
            r_op_a       <= io_md.dx_a;
            r_op_b       <= io_md.dx_b;
            r_rd         <= io_md.dx_insn[26:22];
            r_is_div     <= w_is_div_insn;
            r_exc        <= 1'b0;
            r_start_mult <= !w_is_div_insn;
            r_start_div  <= w_is_div_insn;
          end
        end
        ST_BUSY: begin
          // md_exception only means something alongside md_ready.
          if (io_md.md_ready) begin
            r_result <= io_md.md_result;
            r_exc    <= io_md.md_exception;
          end else if (w_timeout_hit) begin
            r_exc <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_md.md_op_a       = r_op_a;
  assign io_md.md_op_b       = r_op_b;
  assign io_md.md_start_mult = r_start_mult;
  assign io_md.md_start_div  = r_start_div;

endmodule
